sysid_verify_ctrl: RTL and testbench

//  Avalon-MM read master that sequences the system-ID slave after reset or on request.

---
 rtl/sysid_verify_ctrl_if.sv | 29 ++
 rtl/sysid_verify_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sysid_verify_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_verify_ctrl_if.sv
// ---------------------------------------------------------------------------
// sysid_verify_ctrl_if
//   Avalon-MM read-only link between the system-ID verifier (master) and the
//   system-ID slave.
//   avm_read         master -> slave  read request
//   avm_address      master -> slave  0 = ID word, 1 = timestamp word
//   avm_waitrequest  slave -> master  stall; master holds request while high
//   avm_readdata     slave -> master  data, valid when read=1 and waitrequest=0
// ---------------------------------------------------------------------------
interface sysid_verify_ctrl_if;
  logic        avm_read;
  logic        avm_address;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_read,
    output avm_address,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_read,
    input  avm_address,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_verify_ctrl.sv
// ---------------------------------------------------------------------------
// sysid_verify_ctrl
//   Reads the system-ID slave (word 0 = ID, word 1 = build timestamp) after
//   reset release or on a start pulse, compares both words with the expected
//   values and reports the outcome to boot-control logic, so no software
//   polling of the sysid block is needed.
//
// Ports
//   clock        system clock, rising edge
//   reset_n      synchronous active-low reset
//   start        pulse; begins a check (ignored while busy)
//   avm          Avalon-MM master side (read / address / waitrequest / readdata)
//   busy         check in progress
//   done         check finished; held until the next start
//   pass         done and both words matched, no timeout
//   id_mismatch  ID word differs from EXP_ID
//   ts_mismatch  timestamp word differs from EXP_TIMESTAMP
//   timeout      a word exhausted its retries
//   id_value     last captured ID word
//   ts_value     last captured timestamp word
// ---------------------------------------------------------------------------
module sysid_verify_ctrl #(
  parameter logic [31:0] EXP_ID         = 32'd0,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'd1396564150,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned RETRIES        = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  sysid_verify_ctrl_if.master        avm,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       id_mismatch,
  output logic                       ts_mismatch,
  output logic                       timeout,
  output logic [31:0]                id_value,
  output logic [31:0]                ts_value
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        RETRY_MAX = 4'(RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    BACKOFF,
    CHECK,
    DONE
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        retry_cnt;
  // Set by reset so the first cycle after release launches a check by itself.
  logic              auto_pend;

  // NOTE: all state and outputs use non-blocking assignments so every
  // register samples pre-edge values; blocking here would create order-
  // dependent races between the counters and the state transitions.
  always_ff @(posedge clock) begin
    // NOTE: reset is sampled at the edge (synchronous), so it belongs inside
    // the clocked block and not in the sensitivity list.
    if (!reset_n) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      retry_cnt       <= '0;
      auto_pend       <= AUTO_START;
      avm.avm_read    <= 1'b0;
      avm.avm_address <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      id_mismatch     <= 1'b0;
      ts_mismatch     <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      ts_value        <= '0;
    end else begin
      auto_pend <= 1'b0;

      case (state)
        IDLE: begin
          if (start || auto_pend) begin
            state           <= RD_ID;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= 1'b0;
            busy            <= 1'b1;
            wait_cnt        <= '0;
            retry_cnt       <= '0;
          end
        end

        RD_ID, RD_TS: begin
          if (!avm.avm_waitrequest) begin
            wait_cnt  <= '0;
            retry_cnt <= '0;
            if (state == RD_ID) begin
              id_value        <= avm.avm_readdata;
              avm.avm_address <= 1'b1;
              state           <= RD_TS;
            end else begin
              ts_value     <= avm.avm_readdata;
              avm.avm_read <= 1'b0;
              state        <= CHECK;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Attempt stalled too long: drop the request and either back off
            // for a retry or give up on the whole check.
            wait_cnt     <= '0;
            avm.avm_read <= 1'b0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 4'd1;
              state     <= BACKOFF;
            end else begin
              timeout <= 1'b1;
              state   <= DONE;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        BACKOFF: begin
          // The held address tells which word to go back to.
          wait_cnt     <= '0;
          avm.avm_read <= 1'b1;
          state        <= avm.avm_address ? RD_TS : RD_ID;
        end

        CHECK: begin
          id_mismatch <= (id_value != EXP_ID);
          ts_mismatch <= (ts_value != EXP_TIMESTAMP);
          state       <= DONE;
        end

        DONE: begin
          // A start only counts once the result is published (done=1).
          if (done && start) begin
            done            <= 1'b0;
            pass            <= 1'b0;
            id_mismatch     <= 1'b0;
            ts_mismatch     <= 1'b0;
            timeout         <= 1'b0;
            busy            <= 1'b1;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= 1'b0;
            wait_cnt        <= '0;
            retry_cnt       <= '0;
            state           <= RD_ID;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
            pass <= !(id_mismatch || ts_mismatch || timeout);
          end
        end

        default: begin
          state        <= IDLE;
          avm.avm_read <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sysid_verify_ctrl
//   Self-checking bench for sysid_verify_ctrl. A behavioural sysid slave
//   serves two words and stalls each read attempt by a scripted number of
//   cycles; a transaction-level model predicts latency, attempts per word and
//   the final flags from the stall script.
// ---------------------------------------------------------------------------
module tb_sysid_verify_ctrl;

  localparam int          TO     = 4;
  localparam int          RT     = 2;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1396564150;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  sysid_verify_ctrl_if avm ();

  sysid_verify_ctrl #(
    .EXP_ID         (EXP_ID),
    .EXP_TIMESTAMP  (EXP_TS),
    .TIMEOUT_CYCLES (TO),
    .RETRIES        (RT),
    .AUTO_START     (1'b1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .avm         (avm),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .id_mismatch (id_mismatch),
    .ts_mismatch (ts_mismatch),
    .timeout     (timeout),
    .id_value    (id_value),
    .ts_value    (ts_value)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // ---------------- behavioural sysid slave ----------------
  logic [31:0] slv_word [2];
  int          stall_q[$];
  bit          in_att     = 1'b0;
  int          stall_left = 0;
  int          att_cnt [2] = '{0, 0};
  int          stable_err = 0;
  logic        prev_read = 1'b0, prev_wait = 1'b0, prev_addr = 1'b0;

  initial begin
    avm.avm_waitrequest = 1'b0;
    avm.avm_readdata    = '0;
  end

  always @(negedge clock) begin
    if (avm.avm_read === 1'b1) begin
      // Request must not move while it is being stalled.
      if (prev_read && prev_wait && (avm.avm_address !== prev_addr))
        stable_err++;
      if (!in_att) begin
        in_att     = 1'b1;
        stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
        att_cnt[int'(avm.avm_address)]++;
      end
      if (stall_left > 0) begin
        avm.avm_waitrequest = 1'b1;
        avm.avm_readdata    = $urandom;
        stall_left--;
      end else begin
        avm.avm_waitrequest = 1'b0;
        avm.avm_readdata    = slv_word[int'(avm.avm_address)];
        in_att              = 1'b0;
      end
    end else begin
      in_att              = 1'b0;
      avm.avm_waitrequest = 1'($urandom_range(0, 1));
      avm.avm_readdata    = $urandom;
    end
    prev_read = avm.avm_read;
    prev_wait = avm.avm_waitrequest;
    prev_addr = avm.avm_address;
  end

  // ---------------- reference expectations ----------------
  logic [31:0] exp_id_val = '0;
  logic [31:0] exp_ts_val = '0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete check. auto_kick=1 launches it by releasing reset,
  // otherwise by a start pulse from DONE. poke=1 pulses start mid-run.
  task automatic run(input string tag, input logic [31:0] idw, input logic [31:0] tsw,
                     input bit auto_kick, input bit poke);
    int mq[$];
    int lat, idx, s, att0, att1, base0, base1, c;
    bit to, ok0, ok1, id_m, ts_m;

    // Model: walk the stall script attempt by attempt.
    mq = stall_q;
    lat = 0; idx = 0; to = 1'b0; ok0 = 1'b0; ok1 = 1'b0; att0 = 0; att1 = 0;
    for (int w = 0; w < 2; w++) begin
      if (to) break;
      for (int a = 0; a <= RT; a++) begin
        s = (idx < mq.size()) ? mq[idx] : 0;
        idx++;
        if (w == 0) att0++; else att1++;
        if (s < TO) begin
          lat += s + 1;
          if (w == 0) ok0 = 1'b1; else ok1 = 1'b1;
          break;
        end
        lat += TO;
        if (a < RT) lat += 1;
        else        to = 1'b1;
      end
    end
    lat += to ? 1 : 2;
    if (ok0) exp_id_val = idw;
    if (ok1) exp_ts_val = tsw;
    id_m = !to && (idw != EXP_ID);
    ts_m = !to && (tsw != EXP_TS);

    slv_word[0] = idw;
    slv_word[1] = tsw;
    base0 = att_cnt[0];
    base1 = att_cnt[1];

    if (auto_kick) reset_n = 1'b1;
    else           start   = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".busy_on"},  32'(busy), 32'd1);
    check({tag, ".done_low"}, 32'(done), 32'd0);
    check({tag, ".read_on"},  32'(avm.avm_read), 32'd1);
    check({tag, ".addr0"},    32'(avm.avm_address), 32'd0);
    if (!auto_kick) begin
      check({tag, ".pass_clr"}, 32'(pass), 32'd0);
      check({tag, ".to_clr"},   32'(timeout), 32'd0);
    end

    c = 0;
    while (!done && c < 200) begin
      if (poke && c == 1) start = 1'b1;
      tick();
      start = 1'b0;
      c++;
    end
    check({tag, ".latency"},  32'(c), 32'(lat));
    check({tag, ".busy_off"}, 32'(busy), 32'd0);
    check({tag, ".timeout"},  32'(timeout), 32'(to));
    check({tag, ".pass"},     32'(pass), 32'(!to && !id_m && !ts_m));
    if (!to) begin
      check({tag, ".id_mis"}, 32'(id_mismatch), 32'(id_m));
      check({tag, ".ts_mis"}, 32'(ts_mismatch), 32'(ts_m));
    end
    check({tag, ".id_val"},   id_value, exp_id_val);
    check({tag, ".ts_val"},   ts_value, exp_ts_val);
    check({tag, ".att_id"},   32'(att_cnt[0] - base0), 32'(att0));
    check({tag, ".att_ts"},   32'(att_cnt[1] - base1), 32'(att1));

    // Result must hold while done stays high.
    tick();
    tick();
    check({tag, ".done_hold"}, 32'(done), 32'd1);
    check({tag, ".read_idle"}, 32'(avm.avm_read), 32'd0);
    check({tag, ".pass_hold"}, 32'(pass), 32'(!to && !id_m && !ts_m));
    stall_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] idw, tsw;
    int c;

    // Reset state
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst.read",   32'(avm.avm_read), 32'd0);
    check("rst.busy",   32'(busy), 32'd0);
    check("rst.done",   32'(done), 32'd0);
    check("rst.pass",   32'(pass), 32'd0);
    check("rst.to",     32'(timeout), 32'd0);
    check("rst.id_val", id_value, 32'd0);
    check("rst.ts_val", ts_value, 32'd0);

    // T1: automatic check after reset release, zero-wait slave
    run("t1", EXP_ID, EXP_TS, 1'b1, 1'b0);
    // T2 + T5: ID mismatch, with a start pulse while busy
    run("t2", 32'd1, EXP_TS, 1'b0, 1'b1);
    // T3: three stall cycles on each word
    stall_q = '{3, 3};
    run("t3", EXP_ID, EXP_TS, 1'b0, 1'b0);
    // T4: ID word never answers
    stall_q = '{4, 4, 4};
    run("t4", EXP_ID, EXP_TS, 1'b0, 1'b0);
    // Retries that eventually succeed on both words
    stall_q = '{4, 2, 4, 4, 1};
    run("retry", EXP_ID, 32'h1234_5678, 1'b0, 1'b0);
    // Timestamp word never answers
    stall_q = '{0, 4, 4, 4};
    run("ts_to", 32'hdead_beef, EXP_TS, 1'b0, 1'b0);

    // Randomized runs
    for (int i = 0; i < 12; i++) begin
      stall_q.delete();
      for (int k = 0; k < 6; k++) stall_q.push_back(int'($urandom_range(0, TO)));
      idw = ($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_ID;
      tsw = ($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_TS;
      run($sformatf("rnd%0d", i), idw, tsw, 1'b0, ($urandom_range(0, 1) == 1));
    end

    // T6: reset while the timestamp word is being read
    stall_q = '{0, 3};
    slv_word[0] = EXP_ID;
    slv_word[1] = EXP_TS;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!(avm.avm_read === 1'b1 && avm.avm_address === 1'b1) && c < 50) begin
      tick();
      c++;
    end
    check("t6.reach_ts", 32'(c < 50), 32'd1);
    reset_n = 1'b0;
    tick();
    check("t6.read",   32'(avm.avm_read), 32'd0);
    check("t6.busy",   32'(busy), 32'd0);
    check("t6.done",   32'(done), 32'd0);
    check("t6.pass",   32'(pass), 32'd0);
    check("t6.id_val", id_value, 32'd0);
    check("t6.ts_val", ts_value, 32'd0);
    exp_id_val = '0;
    exp_ts_val = '0;
    stall_q.delete();
    run("t6.rerun", EXP_ID, EXP_TS, 1'b1, 1'b0);

    check("addr_stable", 32'(stable_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
